// File: rtl/bidir_fifo_port_ctrl.sv
// bidir_fifo_port_ctrl: one side of a shared-RAM bidirectional FIFO.
// Stream adapter, read skid buffer and direction turnaround sequencer.
module bidir_fifo_port_ctrl #(
  parameter int    DSIZE       = 8,
  parameter string FALLTHROUGH = "TRUE",
  parameter int    TURN_CYC    = 4,
  parameter logic  RST_DIR     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dir_req,
  output logic             dir,
  output logic             dir_ack,
  output logic             busy,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DSIZE-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             f_winc,
  output logic [DSIZE-1:0] f_wdata,
  input  logic             f_full,
  output logic             f_rinc,
  input  logic [DSIZE-1:0] f_rdata,
  input  logic             f_empty
);

  typedef enum logic [1:0] {
    ST_WR,
    ST_TURN,
    ST_RD
  } state_t;

  localparam bit         FT      = (FALLTHROUGH == "TRUE");
  localparam logic [3:0] TC_LAST = 4'(TURN_CYC - 1);
  localparam state_t     ST_RST  = RST_DIR ? ST_WR : ST_RD;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dir;
  logic [3:0]       r_cnt;
  logic [1:0]       r_bcnt;
  logic             r_head;
  logic             r_infl;
  logic [DSIZE-1:0] r_buf [2];

  logic             w_pop;
  logic             w_push;
  logic             w_rinc;
  logic             w_sready;
  logic             w_widx;
  logic [2:0]       w_occ;

  assign w_pop  = m_valid & m_ready;
  assign w_occ  = 3'(r_bcnt) + 3'(r_infl);
  assign w_push = FT ? f_rinc : r_infl;
  assign w_widx = r_head ^ r_bcnt[0];

  // Next state and handshake strobes for the current role.
  always_comb begin
    w_state_nxt = r_state;
    w_sready    = 1'b0;
    w_rinc      = 1'b0;
    unique case (r_state)
      ST_WR: begin
        w_sready = !f_full;
        if (!dir_req) w_state_nxt = ST_TURN;
      end
      ST_RD: begin
        w_rinc = !f_empty && (w_occ < (3'd2 + 3'(w_pop)));
        if (dir_req && r_bcnt == 2'd0 && !r_infl && !w_rinc)
          w_state_nxt = ST_TURN;
      end
      ST_TURN: begin
        if (r_cnt == TC_LAST)
          w_state_nxt = r_dir ? ST_RD : ST_WR;
      end
      default: w_state_nxt = ST_RST;
    endcase
  end

  // State, direction and guard counter; dir flips only when TURN ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RST;
      r_dir   <= RST_DIR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_TURN) begin
        if (r_cnt == TC_LAST) begin
          r_cnt <= '0;
          r_dir <= !r_dir;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  // Read buffer occupancy, head pointer and in-flight read tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bcnt <= '0;
      r_head <= 1'b0;
      r_infl <= 1'b0;
    end else begin
      r_infl <= FT ? 1'b0 : f_rinc;
      if (w_pop) r_head <= !r_head;
      r_bcnt <= r_bcnt + 2'(w_push) - 2'(w_pop);
    end
  end

  // Read buffer storage; contents are meaningless while count is zero.
  always_ff @(posedge clk) begin
    if (w_push) r_buf[w_widx] <= f_rdata;
  end

  assign s_ready = w_sready & rst_n;
  assign f_winc  = s_valid & s_ready;
  assign f_wdata = s_data;
  assign f_rinc  = w_rinc & rst_n;
  assign m_valid = (r_bcnt != 2'd0);
  assign m_data  = r_buf[r_head];
  assign dir     = r_dir;
  assign dir_ack = (r_state != ST_TURN) && (r_dir == dir_req);
  assign busy    = (r_state == ST_TURN) || (r_bcnt != 2'd0) || r_infl;

endmodule

// File: tb/tb_bidir_fifo_port_ctrl.sv
// tb_bidir_fifo_port_ctrl: bench for both read-latency variants.
// Queue-based FIFO models and write/read scoreboards.
module tb_bidir_fifo_port_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, dir_req, s_valid, m_ready, f_full;
  logic [7:0] s_data;

  logic       a_dir, a_ack, a_busy, a_sready, a_mvalid;
  logic       a_winc, a_rinc, a_empty;
  logic [7:0] a_mdata, a_wdata, a_rdata;
  logic       b_dir, b_ack, b_busy, b_sready, b_mvalid;
  logic       b_winc, b_rinc, b_empty;
  logic [7:0] b_mdata, b_wdata, b_rdata;

  logic [7:0] fifo_a[$], fifo_b[$];
  logic [7:0] exp_wr_a[$], exp_wr_b[$];
  logic [7:0] exp_rd_a[$], exp_rd_b[$];
  int n_cmp = 0;
  int n_err = 0;
  int rinc_a = 0;
  int rinc_b = 0;

  bidir_fifo_port_ctrl #(
    .DSIZE(8), .FALLTHROUGH("FALSE"), .TURN_CYC(4), .RST_DIR(1'b1)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .dir_req(dir_req),
    .dir(a_dir), .dir_ack(a_ack), .busy(a_busy),
    .s_valid(s_valid), .s_ready(a_sready), .s_data(s_data),
    .m_valid(a_mvalid), .m_ready(m_ready), .m_data(a_mdata),
    .f_winc(a_winc), .f_wdata(a_wdata), .f_full(f_full),
    .f_rinc(a_rinc), .f_rdata(a_rdata), .f_empty(a_empty)
  );

  bidir_fifo_port_ctrl #(
    .DSIZE(8), .FALLTHROUGH("TRUE"), .TURN_CYC(4), .RST_DIR(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .dir_req(dir_req),
    .dir(b_dir), .dir_ack(b_ack), .busy(b_busy),
    .s_valid(s_valid), .s_ready(b_sready), .s_data(s_data),
    .m_valid(b_mvalid), .m_ready(m_ready), .m_data(b_mdata),
    .f_winc(b_winc), .f_wdata(b_wdata), .f_full(f_full),
    .f_rinc(b_rinc), .f_rdata(b_rdata), .f_empty(b_empty)
  );

  task automatic load(input logic [7:0] w);
    fifo_a.push_back(w);
    fifo_b.push_back(w);
    exp_rd_a.push_back(w);
    exp_rd_b.push_back(w);
    a_empty = 1'b0;
    b_empty = 1'b0;
    b_rdata = fifo_b[0];
  endtask

  // One clock: score handshakes seen this cycle, then advance FIFO models.
  task automatic tick();
    logic ra, rb;
    logic [7:0] e;
    #1;
    ra = a_rinc;
    rb = b_rinc;
    if (a_winc) begin
      n_cmp++;
      if (exp_wr_a.size() == 0) begin
        n_err++;
        $display("FAIL wr_a: got %h, required no write", a_wdata);
      end else begin
        e = exp_wr_a.pop_front();
        if (a_wdata !== e) begin
          n_err++;
          $display("FAIL wr_a: got %h, required %h", a_wdata, e);
        end
      end
    end
    if (b_winc) begin
      n_cmp++;
      if (exp_wr_b.size() == 0) begin
        n_err++;
        $display("FAIL wr_b: got %h, required no write", b_wdata);
      end else begin
        e = exp_wr_b.pop_front();
        if (b_wdata !== e) begin
          n_err++;
          $display("FAIL wr_b: got %h, required %h", b_wdata, e);
        end
      end
    end
    if (a_mvalid === 1'b1 && m_ready) begin
      n_cmp++;
      if (exp_rd_a.size() == 0) begin
        n_err++;
        $display("FAIL rd_a: got %h, required no word", a_mdata);
      end else begin
        e = exp_rd_a.pop_front();
        if (a_mdata !== e) begin
          n_err++;
          $display("FAIL rd_a: got %h, required %h", a_mdata, e);
        end
      end
    end
    if (b_mvalid === 1'b1 && m_ready) begin
      n_cmp++;
      if (exp_rd_b.size() == 0) begin
        n_err++;
        $display("FAIL rd_b: got %h, required no word", b_mdata);
      end else begin
        e = exp_rd_b.pop_front();
        if (b_mdata !== e) begin
          n_err++;
          $display("FAIL rd_b: got %h, required %h", b_mdata, e);
        end
      end
    end
    if (ra && fifo_a.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL rinc_a_empty: got rinc=1, required 0");
    end
    if (rb && fifo_b.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL rinc_b_empty: got rinc=1, required 0");
    end
    @(posedge clk);
    #1;
    if (ra) begin
      rinc_a++;
      if (fifo_a.size() > 0) a_rdata = fifo_a.pop_front();
      a_empty = (fifo_a.size() == 0);
    end
    if (rb) begin
      rinc_b++;
      if (fifo_b.size() > 0) void'(fifo_b.pop_front());
      b_empty = (fifo_b.size() == 0);
      b_rdata = b_empty ? 8'h00 : fifo_b[0];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dir_req = 1'b1; s_valid = 1'b1;
    s_data = 8'hA5; f_full = 1'b0; m_ready = 1'b0;
    repeat (3) tick();
    #1;
    n_cmp++;
    if ({a_sready, a_winc, a_rinc, a_mvalid, a_busy, a_dir} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_a: got %b, required 000001",
               {a_sready, a_winc, a_rinc, a_mvalid, a_busy, a_dir});
    end
    n_cmp++;
    if ({b_sready, b_winc, b_rinc, b_mvalid, b_busy, b_dir} !== 6'b000001) begin
      n_err++;
      $display("FAIL reset_b: got %b, required 000001",
               {b_sready, b_winc, b_rinc, b_mvalid, b_busy, b_dir});
    end
    rst_n = 1'b1;
    exp_wr_a.push_back(8'hA5);
    exp_wr_b.push_back(8'hA5);
    #1;
    n_cmp++;
    if ({a_dir, a_sready, a_winc, a_wdata} !== {3'b111, 8'hA5}) begin
      n_err++;
      $display("FAIL first_wr_a: got %b/%h, required 111/a5",
               {a_dir, a_sready, a_winc}, a_wdata);
    end
    n_cmp++;
    if ({b_dir, b_sready, b_winc, b_wdata} !== {3'b111, 8'hA5}) begin
      n_err++;
      $display("FAIL first_wr_b: got %b/%h, required 111/a5",
               {b_dir, b_sready, b_winc}, b_wdata);
    end
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_full();
    s_valid = 1'b1; s_data = 8'h5C; f_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({a_sready, a_winc, b_sready, b_winc} !== 4'b0000) begin
        n_err++;
        $display("FAIL full_hold: got %b, required 0000",
                 {a_sready, a_winc, b_sready, b_winc});
      end
      tick();
    end
    f_full = 1'b0;
    exp_wr_a.push_back(8'h5C);
    exp_wr_b.push_back(8'h5C);
    #1;
    n_cmp++;
    if ({a_winc, b_winc} !== 2'b11) begin
      n_err++;
      $display("FAIL full_release: got %b, required 11", {a_winc, b_winc});
    end
    tick();
    s_valid = 1'b0;
    #1;
    n_cmp++;
    if (exp_wr_a.size() + exp_wr_b.size() != 0) begin
      n_err++;
      $display("FAIL full_pending: got %0d, required 0",
               exp_wr_a.size() + exp_wr_b.size());
    end
    repeat (2) tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    int idx;
    words[0] = 8'h31; words[1] = 8'h32; words[2] = 8'h33; words[3] = 8'h34;
    idx = 0;
    s_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      f_full = (c == 2 || c == 3);
      s_data = words[idx];
      if (!f_full) begin
        exp_wr_a.push_back(words[idx]);
        exp_wr_b.push_back(words[idx]);
        idx++;
      end
      tick();
    end
    s_valid = 1'b0; f_full = 1'b0;
    #1;
    n_cmp++;
    if (exp_wr_a.size() + exp_wr_b.size() != 0) begin
      n_err++;
      $display("FAIL b2b_pending: got %0d, required 0",
               exp_wr_a.size() + exp_wr_b.size());
    end
  endtask

  task automatic test_turn_wr_to_rd();
    s_valid = 1'b1; s_data = 8'hC3; dir_req = 1'b0;
    exp_wr_a.push_back(8'hC3);
    exp_wr_b.push_back(8'hC3);
    #1;
    n_cmp++;
    if ({a_winc, b_winc, a_ack, b_ack} !== 4'b1100) begin
      n_err++;
      $display("FAIL turn_last_wr: got %b, required 1100",
               {a_winc, b_winc, a_ack, b_ack});
    end
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({a_dir, a_sready, a_busy, a_ack, b_dir, b_sready, b_busy, b_ack}
          !== 8'b1010_1010) begin
        n_err++;
        $display("FAIL turn_hold%0d: got %b, required 10101010", i,
                 {a_dir, a_sready, a_busy, a_ack, b_dir, b_sready, b_busy, b_ack});
      end
      tick();
    end
    #1;
    n_cmp++;
    if ({a_dir, a_ack, a_busy, a_sready, b_dir, b_ack, b_busy, b_sready}
        !== 8'b0100_0100) begin
      n_err++;
      $display("FAIL turn_to_rd: got %b, required 01000100",
               {a_dir, a_ack, a_busy, a_sready, b_dir, b_ack, b_busy, b_sready});
    end
  endtask

  task automatic test_read();
    rinc_a = 0; rinc_b = 0; m_ready = 1'b0;
    load(8'h11); load(8'h22); load(8'h33);
    tick();
    #1;
    n_cmp++;
    if ({a_mvalid, b_mvalid} !== 2'b01) begin
      n_err++;
      $display("FAIL rd_latency1: got %b, required 01", {a_mvalid, b_mvalid});
    end
    tick();
    #1;
    n_cmp++;
    if ({a_mvalid, b_mvalid, a_mdata, b_mdata} !== {2'b11, 8'h11, 8'h11}) begin
      n_err++;
      $display("FAIL rd_head: got %b %h %h, required 11 11 11",
               {a_mvalid, b_mvalid}, a_mdata, b_mdata);
    end
    repeat (3) tick();
    #1;
    n_cmp++;
    if (rinc_a != 2 || rinc_b != 2 || a_mdata !== 8'h11) begin
      n_err++;
      $display("FAIL rd_two_rinc: got %0d/%0d %h, required 2/2 11",
               rinc_a, rinc_b, a_mdata);
    end
    m_ready = 1'b1;
    repeat (3) tick();
    m_ready = 1'b0;
    #1;
    n_cmp++;
    if ({a_mvalid, b_mvalid, a_empty, b_empty, a_busy, b_busy} !== 6'b001100
        || rinc_a != 3 || rinc_b != 3
        || exp_rd_a.size() + exp_rd_b.size() != 0) begin
      n_err++;
      $display("FAIL rd_drain: got %b %0d/%0d q%0d, required 001100 3/3 q0",
               {a_mvalid, b_mvalid, a_empty, b_empty, a_busy, b_busy},
               rinc_a, rinc_b, exp_rd_a.size() + exp_rd_b.size());
    end
  endtask

  task automatic test_rd_to_wr();
    load(8'h44);
    repeat (3) tick();
    dir_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({a_dir, a_busy, a_ack, a_mvalid, b_dir, b_busy, b_ack, b_mvalid}
          !== 8'b0101_0101) begin
        n_err++;
        $display("FAIL rd_hold%0d: got %b, required 01010101", i,
                 {a_dir, a_busy, a_ack, a_mvalid, b_dir, b_busy, b_ack, b_mvalid});
      end
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    #1;
    n_cmp++;
    if ({a_dir, a_busy, a_mvalid, b_dir, b_busy, b_mvalid} !== 6'b000000) begin
      n_err++;
      $display("FAIL rd_popped: got %b, required 000000",
               {a_dir, a_busy, a_mvalid, b_dir, b_busy, b_mvalid});
    end
    tick();
    #1;
    n_cmp++;
    if ({a_dir, a_busy, a_ack, b_dir, b_busy, b_ack} !== 6'b010010) begin
      n_err++;
      $display("FAIL rd_turn: got %b, required 010010",
               {a_dir, a_busy, a_ack, b_dir, b_busy, b_ack});
    end
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    #1;
    n_cmp++;
    if ({a_dir, a_busy, a_mvalid, a_ack, b_dir, b_busy, b_mvalid, b_ack}
        !== 8'b1001_1001) begin
      n_err++;
      $display("FAIL turn_reset: got %b, required 10011001",
               {a_dir, a_busy, a_mvalid, a_ack, b_dir, b_busy, b_mvalid, b_ack});
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({a_sready, b_sready} !== 2'b11) begin
      n_err++;
      $display("FAIL turn_reset_wr: got %b, required 11", {a_sready, b_sready});
    end
  endtask

  task automatic test_reset_abort();
    dir_req = 1'b0;
    repeat (5) tick();
    #1;
    n_cmp++;
    if ({a_dir, b_dir} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_rd: got %b, required 00", {a_dir, b_dir});
    end
    load(8'h66); load(8'h77);
    repeat (3) tick();
    #1;
    n_cmp++;
    if ({a_mvalid, b_mvalid, a_mdata, b_mdata} !== {2'b11, 8'h66, 8'h66}) begin
      n_err++;
      $display("FAIL abort_buf: got %b %h %h, required 11 66 66",
               {a_mvalid, b_mvalid}, a_mdata, b_mdata);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fifo_a.delete(); fifo_b.delete();
    exp_rd_a.delete(); exp_rd_b.delete();
    a_empty = 1'b1; b_empty = 1'b1;
    #1;
    n_cmp++;
    if ({a_mvalid, a_busy, a_dir, b_mvalid, b_busy, b_dir} !== 6'b001001) begin
      n_err++;
      $display("FAIL abort_clear: got %b, required 001001",
               {a_mvalid, a_busy, a_dir, b_mvalid, b_busy, b_dir});
    end
  endtask

  task automatic test_turn_revert();
    tick();
    dir_req = 1'b1;
    repeat (3) tick();
    #1;
    n_cmp++;
    if ({a_dir, a_busy, b_dir, b_busy} !== 4'b1111) begin
      n_err++;
      $display("FAIL revert_turn: got %b, required 1111",
               {a_dir, a_busy, b_dir, b_busy});
    end
    tick();
    #1;
    n_cmp++;
    if ({a_dir, a_ack, a_busy, b_dir, b_ack, b_busy} !== 6'b000000) begin
      n_err++;
      $display("FAIL revert_rd: got %b, required 000000",
               {a_dir, a_ack, a_busy, b_dir, b_ack, b_busy});
    end
    tick();
    #1;
    n_cmp++;
    if ({a_dir, a_busy, b_dir, b_busy} !== 4'b0101) begin
      n_err++;
      $display("FAIL revert_turn2: got %b, required 0101",
               {a_dir, a_busy, b_dir, b_busy});
    end
    repeat (4) tick();
    #1;
    n_cmp++;
    if ({a_dir, a_ack, a_busy, a_sready, b_dir, b_ack, b_busy, b_sready}
        !== 8'b1101_1101) begin
      n_err++;
      $display("FAIL revert_wr: got %b, required 11011101",
               {a_dir, a_ack, a_busy, a_sready, b_dir, b_ack, b_busy, b_sready});
    end
  endtask

  initial begin
    a_empty = 1'b1; b_empty = 1'b1;
    a_rdata = 8'h00; b_rdata = 8'h00;
    rst_n = 1'b0; dir_req = 1'b1; s_valid = 1'b0;
    s_data = 8'h00; m_ready = 1'b0; f_full = 1'b0;
    test_reset();
    test_full();
    test_back_to_back();
    test_turn_wr_to_rd();
    test_read();
    test_rd_to_wr();
    test_reset_abort();
    test_turn_revert();
    n_cmp++;
    if (exp_wr_a.size() + exp_wr_b.size() + exp_rd_a.size() + exp_rd_b.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d queued, required 0",
               exp_wr_a.size() + exp_wr_b.size() + exp_rd_a.size() + exp_rd_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
